// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver (5..DBIT_MAX data bits,
// none/even/odd parity, 1 or 2 stop bits) driven by an oversampling tick.
// Build option: define UART_RX_MAJORITY_EN to take each data/parity/stop
// bit as the majority of three samples instead of a single sample.
module uart_rx_cfg #(
   parameter int DBIT_MAX   = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_tick,
   input  logic                rx,
   input  logic [3:0]          data_len,
   input  logic [1:0]          par_mode,
   input  logic                stop2,
   output logic [DBIT_MAX-1:0] dout,
   output logic                rx_done_tick,
   output logic                parity_err,
   output logic                frame_err,
   output logic                busy
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              state_q, state_d;
   logic [SW-1:0]       s_q, s_d;
   logic [4:0]          n_q, n_d;        // data bit index, reused as stop bit index
   logic [4:0]          len_q, len_d;
   logic                par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
   logic [DBIT_MAX-1:0] sr_q, sr_d;
   logic                perr_q, perr_d, ferr_q, ferr_d;
   logic [DBIT_MAX-1:0] dout_q, dout_d;
   logic                done_q, done_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;
   logic                sync1_q, rx_s;
   logic [4:0]          len_clamp;
   logic                bit_val;
   logic                par_exp;

`ifdef UART_RX_MAJORITY_EN
   localparam logic [SW-1:0] S_MA = SW'(OVERSAMPLE - 3);
   localparam logic [SW-1:0] S_MB = SW'(OVERSAMPLE - 2);
   logic maj_a_q, maj_a_d, maj_b_q, maj_b_d;

   assign bit_val = (maj_a_q & maj_b_q) | (maj_a_q & rx_s) | (maj_b_q & rx_s);

   // capture the two early samples of each data/parity/stop bit
   always_comb begin
      maj_a_d = maj_a_q;
      maj_b_d = maj_b_q;
      if (s_tick && (state_q == DATA || state_q == PARITY || state_q == STOP)) begin
         if (s_q == S_MA) maj_a_d = rx_s;
         if (s_q == S_MB) maj_b_d = rx_s;
      end
   end

   // early-sample registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         maj_a_q <= 1'b1;
         maj_b_q <= 1'b1;
      end else begin
         maj_a_q <= maj_a_d;
         maj_b_q <= maj_b_d;
      end
   end
`else
   assign bit_val = rx_s;
`endif

   assign par_exp      = par_odd_q ? ~(^sr_q) : (^sr_q);
   assign dout         = dout_q;
   assign rx_done_tick = done_q;
   assign parity_err   = parity_err_q;
   assign frame_err    = frame_err_q;
   assign busy         = (state_q != IDLE);

   // clamp requested data length into 5..DBIT_MAX
   always_comb begin
      if (data_len < 4'd5)
         len_clamp = 5'd5;
      else if ({1'b0, data_len} > 5'(DBIT_MAX))
         len_clamp = 5'(DBIT_MAX);
      else
         len_clamp = {1'b0, data_len};
   end

   // frame FSM: next state, counters, shift register and output loads
   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      n_d          = n_q;
      len_d        = len_q;
      par_en_d     = par_en_q;
      par_odd_d    = par_odd_q;
      stop2_d      = stop2_q;
      sr_d         = sr_q;
      perr_d       = perr_q;
      ferr_d       = ferr_q;
      dout_d       = dout_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            s_d = '0;
            n_d = '0;
            if (!rx_s) begin
               state_d   = START;
               len_d     = len_clamp;
               par_en_d  = (par_mode == 2'b01) || (par_mode == 2'b10);
               par_odd_d = (par_mode == 2'b10);
               stop2_d   = stop2;
               sr_d      = '0;
               perr_d    = 1'b0;
               ferr_d    = 1'b0;
            end
         end
         START: if (s_tick) begin
            if (s_q == S_MID) begin
               s_d     = '0;
               state_d = rx_s ? IDLE : DATA;
            end else
               s_d = s_q + SW'(1);
         end
         DATA: if (s_tick) begin
            if (s_q == S_LAST) begin
               s_d  = '0;
               sr_d = sr_q | ({{(DBIT_MAX-1){1'b0}}, bit_val} << n_q);
               if (n_q == len_q - 5'd1) begin
                  n_d     = '0;
                  state_d = par_en_q ? PARITY : STOP;
               end else
                  n_d = n_q + 5'd1;
            end else
               s_d = s_q + SW'(1);
         end
         PARITY: if (s_tick) begin
            if (s_q == S_LAST) begin
               s_d     = '0;
               perr_d  = (bit_val != par_exp);
               state_d = STOP;
            end else
               s_d = s_q + SW'(1);
         end
         STOP: if (s_tick) begin
            if (s_q == S_LAST) begin
               s_d = '0;
               if (!bit_val) ferr_d = 1'b1;
               if (stop2_q && n_q == 5'd0)
                  n_d = 5'd1;
               else begin
                  n_d          = '0;
                  state_d      = IDLE;
                  dout_d       = sr_q;
                  parity_err_d = perr_q;
                  frame_err_d  = ferr_q | ~bit_val;
                  done_d       = 1'b1;
               end
            end else
               s_d = s_q + SW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // synchroniser, FSM state and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b1;
         rx_s         <= 1'b1;
         state_q      <= IDLE;
         s_q          <= '0;
         n_q          <= '0;
         len_q        <= 5'd5;
         par_en_q     <= 1'b0;
         par_odd_q    <= 1'b0;
         stop2_q      <= 1'b0;
         sr_q         <= '0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         dout_q       <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         sync1_q      <= rx;
         rx_s         <= sync1_q;
         state_q      <= state_d;
         s_q          <= s_d;
         n_q          <= n_d;
         len_q        <= len_d;
         par_en_q     <= par_en_d;
         par_odd_q    <= par_odd_d;
         stop2_q      <= stop2_d;
         sr_q         <= sr_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         dout_q       <= dout_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         done_q       <= done_d;
      end
   end
endmodule
